// File: rtl/uart_rx_data_sampling.sv
// UART receiver oversampling front end: synchronises RX_IN, majority-votes three
// samples around the bit centre and assembles the data bits LSB-first.
module uart_rx_data_sampling #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      sample_enable,
  input  logic [4:0]                edge_count,
  input  logic [3:0]                bit_count,
  output logic                      rx_sync,
  output logic                      sampled_bit,
  output logic                      sample_valid,
  output logic [DATA_WIDTH-1:0]     data_byte,
  output logic                      byte_done
);

  logic                      sync_meta;
  logic                      s0;
  logic                      s1;
  logic                      prescale_legal;
  logic [PRESCALE_WIDTH-1:0] mid;
  logic [PRESCALE_WIDTH-1:0] edge_ext;
  logic                      sampling;
  logic                      vote;

  assign prescale_legal = (Prescale == PRESCALE_WIDTH'(8))  ||
                          (Prescale == PRESCALE_WIDTH'(16)) ||
                          (Prescale == PRESCALE_WIDTH'(32));
  assign mid      = Prescale >> 1;
  assign edge_ext = PRESCALE_WIDTH'(edge_count);
  assign sampling = sample_enable && prescale_legal;
  assign vote     = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

  // RX_IN is asynchronous to clk, so it passes through two flops before any use
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      rx_sync   <= 1'b1;
    end else begin
      sync_meta <= RX_IN;
      rx_sync   <= sync_meta;
    end
  end

  // The third sample is voted directly from rx_sync on the edge after the centre
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      byte_done    <= 1'b0;
      data_byte    <= '0;
    end else begin
      sample_valid <= 1'b0;
      byte_done    <= 1'b0;
      if (!sample_enable) begin
        s0 <= 1'b1;
        s1 <= 1'b1;
      end else if (sampling) begin
        if (edge_ext == mid - PRESCALE_WIDTH'(1)) begin
          s0 <= rx_sync;
        end
        if (edge_ext == mid) begin
          s1 <= rx_sync;
        end
        if (edge_ext == mid + PRESCALE_WIDTH'(1)) begin
          sampled_bit  <= vote;
          sample_valid <= 1'b1;
          byte_done    <= (bit_count == 4'(DATA_WIDTH));
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_count == 4'(i + 1)) begin
              data_byte[i] <= vote;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_data_sampling.sv
// Directed bench for uart_rx_data_sampling: drives whole frames with a
// behavioural edge/bit counter and checks every strobe cycle by cycle.
module tb_uart_rx_data_sampling;

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       sample_enable;
  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic       rx_sync;
  logic       sampled_bit;
  logic       sample_valid;
  logic [7:0] data_byte;
  logic       byte_done;

  int tests_run;
  int tests_failed;
  int pulses;
  int dones;

  uart_rx_data_sampling #(
    .DATA_WIDTH(8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .RX_IN(RX_IN),
    .Prescale(Prescale),
    .sample_enable(sample_enable),
    .edge_count(edge_count),
    .bit_count(bit_count),
    .rx_sync(rx_sync),
    .sampled_bit(sampled_bit),
    .sample_valid(sample_valid),
    .data_byte(data_byte),
    .byte_done(byte_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Plays one frame (start, 8 data bits LSB first, stop) with the counter
  // values a real edge/bit counter would produce; inputs change on negedge.
  task automatic applyStimulus(input int presc, input logic [7:0] data, input int glitch_bit,
                               input int abort_bit, output int n_valid, output int n_done);
    logic [9:0] frame;
    int         m;
    bit         legal;
    bit         aborted;
    bit         exp_valid;
    bit         exp_done;
    bit         exp_bit;
    frame     = {1'b1, data, 1'b0};
    m         = presc >> 1;
    legal     = (presc == 8) || (presc == 16) || (presc == 32);
    aborted   = 1'b0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_bit   = 1'b1;
    n_valid   = 0;
    n_done    = 0;
    Prescale  = 6'(presc);
    for (int b = 0; b < 10; b++) begin
      for (int e = 0; e < presc; e++) begin
        @(negedge clk);
        if (sample_valid) n_valid++;
        if (byte_done) n_done++;
        checkOutput("sample_valid", 32'(sample_valid), 32'(exp_valid));
        checkOutput("byte_done", 32'(byte_done), 32'(exp_done));
        if (exp_valid) checkOutput("sampled_bit", 32'(sampled_bit), 32'(exp_bit));
        if (b == abort_bit && e == 8) aborted = 1'b1;
        sample_enable = !aborted;
        bit_count     = 4'(b);
        edge_count    = 5'(e);
        RX_IN         = (b == glitch_bit && e == m - 2) ? ~frame[b] : frame[b];
        exp_valid     = legal && !aborted && (e == m + 1);
        exp_done      = exp_valid && (b == 8);
        exp_bit       = frame[b];
      end
    end
    @(negedge clk);
    if (sample_valid) n_valid++;
    if (byte_done) n_done++;
    checkOutput("sample_valid_last", 32'(sample_valid), 32'(exp_valid));
    checkOutput("byte_done_last", 32'(byte_done), 32'(exp_done));
    sample_enable = 1'b0;
    RX_IN         = 1'b1;
    edge_count    = 5'd0;
    bit_count     = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("idle_valid", 32'(sample_valid), 32'd0);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    RX_IN         = 1'b1;
    Prescale      = 6'd16;
    sample_enable = 1'b0;
    edge_count    = 5'd0;
    bit_count     = 4'd0;
    #1;
    checkOutput("reset_rx_sync", 32'(rx_sync), 32'd1);
    checkOutput("reset_sampled_bit", 32'(sampled_bit), 32'd1);
    checkOutput("reset_valid", 32'(sample_valid), 32'd0);
    checkOutput("reset_done", 32'(byte_done), 32'd0);
    checkOutput("reset_data", 32'(data_byte), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(16, 8'hA5, -1, -1, pulses, dones);
    checkOutput("p16_pulses", 32'(pulses), 32'd10);
    checkOutput("p16_dones", 32'(dones), 32'd1);
    checkOutput("p16_data", 32'(data_byte), 32'hA5);

    applyStimulus(8, 8'h3C, -1, -1, pulses, dones);
    checkOutput("p8_pulses", 32'(pulses), 32'd10);
    checkOutput("p8_dones", 32'(dones), 32'd1);
    checkOutput("p8_data", 32'(data_byte), 32'h3C);

    applyStimulus(32, 8'h3C, -1, -1, pulses, dones);
    checkOutput("p32_pulses", 32'(pulses), 32'd10);
    checkOutput("p32_dones", 32'(dones), 32'd1);
    checkOutput("p32_data", 32'(data_byte), 32'h3C);

    applyStimulus(16, 8'h04, 3, -1, pulses, dones);
    checkOutput("glitch_pulses", 32'(pulses), 32'd10);
    checkOutput("glitch_data", 32'(data_byte), 32'h04);

    applyStimulus(12, 8'h81, -1, -1, pulses, dones);
    checkOutput("illegal_pulses", 32'(pulses), 32'd0);
    checkOutput("illegal_dones", 32'(dones), 32'd0);
    checkOutput("illegal_data", 32'(data_byte), 32'h04);

    applyStimulus(16, 8'h5A, -1, 4, pulses, dones);
    checkOutput("abort_pulses", 32'(pulses), 32'd4);
    checkOutput("abort_dones", 32'(dones), 32'd0);

    applyStimulus(16, 8'hFF, -1, -1, pulses, dones);
    checkOutput("ff_pulses", 32'(pulses), 32'd10);
    checkOutput("ff_dones", 32'(dones), 32'd1);
    checkOutput("ff_data", 32'(data_byte), 32'hFF);

    // Sample a low start bit so that the async reset has visible work to undo
    @(negedge clk);
    Prescale      = 6'd16;
    sample_enable = 1'b1;
    bit_count     = 4'd0;
    RX_IN         = 1'b0;
    for (int e = 0; e < 12; e++) begin
      edge_count = 5'(e);
      @(negedge clk);
    end
    checkOutput("pre_reset_sampled_bit", 32'(sampled_bit), 32'd0);
    checkOutput("pre_reset_rx_sync", 32'(rx_sync), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rx_sync", 32'(rx_sync), 32'd1);
    checkOutput("async_sampled_bit", 32'(sampled_bit), 32'd1);
    checkOutput("async_valid", 32'(sample_valid), 32'd0);
    checkOutput("async_done", 32'(byte_done), 32'd0);
    checkOutput("async_data", 32'(data_byte), 32'h00);
    sample_enable = 1'b0;
    RX_IN         = 1'b1;
    edge_count    = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("release_valid", 32'(sample_valid), 32'd0);
    checkOutput("release_done", 32'(byte_done), 32'd0);
    checkOutput("release_data", 32'(data_byte), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
